// File: rtl/debug_clk_ctrl.sv
// debug_clk_ctrl: clock-enable controller for single-clock core debugging.
// Modes: halt, single-step, N-cycle burst and free-run, driven by a debounced
// active-low pushbutton. Optional address breakpoints are built when the
// DBG_BREAKPOINT_EN macro is defined. Without it the breakpoint inputs are
// ignored, and halted_o and bp_hit_o are tied low.
// dbg_state_o exposes the FSM state encoding for checkers and debug.
module debug_clk_ctrl #(
  parameter int ADDR_W          = 32,
  parameter int NUM_BP          = 2,
  parameter int BURST_W         = 8,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [1:0]               mode_i,
  input  logic                     step_key_i,
  input  logic [BURST_W-1:0]       burst_len_i,
  input  logic [ADDR_W-1:0]        pc_i,
  input  logic [NUM_BP*ADDR_W-1:0] bp_addr_i,
  input  logic [NUM_BP-1:0]        bp_valid_i,
  output logic                     cpu_en_o,
  output logic                     halted_o,
  output logic [NUM_BP-1:0]        bp_hit_o,
  output logic [31:0]              cycle_cnt_o,
  output logic [2:0]               dbg_state_o
);

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_STEP  = 2'b01;
  localparam logic [1:0] MODE_BURST = 2'b10;
  localparam logic [1:0] MODE_RUN   = 2'b11;

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STEP    = 3'd1,
    S_BURST   = 3'd2,
    S_RUN     = 3'd3,
    S_BP_HALT = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
  logic               key_sync1, key_sync2;
  logic               key_deb, key_deb_d1;
  logic [DB_W-1:0]    deb_cnt;
  logic               press;
  logic               bp_active;
  logic               cpu_en;

  // Two-flop synchroniser for the asynchronous pushbutton (idle level is 1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sync1 <= 1'b1;
      key_sync2 <= 1'b1;
    end else begin
      key_sync1 <= step_key_i;
      key_sync2 <= key_sync1;
    end
  end

  // Debounce: accept the new level after DEBOUNCE_CYCLES consecutive
  // disagreeing cycles. Register a one-cycle press pulse on a debounced fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_deb    <= 1'b1;
      key_deb_d1 <= 1'b1;
      deb_cnt    <= '0;
      press      <= 1'b0;
    end else begin
      key_deb_d1 <= key_deb;
      press      <= key_deb_d1 & ~key_deb;
      if (key_sync2 != key_deb) begin
        if (deb_cnt == DB_LAST) begin
          key_deb <= key_sync2;
          deb_cnt <= '0;
        end else begin
          deb_cnt <= deb_cnt + 1'b1;
        end
      end else begin
        deb_cnt <= '0;
      end
    end
  end

`ifdef DBG_BREAKPOINT_EN
  logic [NUM_BP-1:0] match;
  logic [NUM_BP-1:0] bp_hit_q;

  // Per-entry address comparators against the current fetch address.
  always_comb begin
    match = '0;
    for (int i = 0; i < NUM_BP; i++) begin
      match[i] = bp_valid_i[i] && (pc_i == bp_addr_i[i*ADDR_W +: ADDR_W]);
    end
  end

  assign bp_active = ((state_q == S_RUN) || (state_q == S_BURST)) && (|match);

  // Sticky hit flags: set when a breakpoint stops the core and cleared when a
  // press steps over it. A simultaneous HALT takes precedence over both.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bp_hit_q <= '0;
    end else if (mode_i != MODE_HALT) begin
      if ((state_q == S_BP_HALT) && press) begin
        bp_hit_q <= '0;
      end else if (bp_active) begin
        bp_hit_q <= bp_hit_q | match;
      end
    end
  end

  assign bp_hit_o = bp_hit_q;
  assign halted_o = (state_q == S_BP_HALT);
`else
  logic unused_bp;
  assign unused_bp = &{1'b0, pc_i, bp_addr_i, bp_valid_i};
  assign bp_active = 1'b0;
  assign bp_hit_o  = '0;
  assign halted_o  = 1'b0;
`endif

  // The core is enabled in the executing states unless it sits on a breakpoint.
  assign cpu_en = ((state_q == S_STEP) || (state_q == S_BURST) || (state_q == S_RUN))
                  && !bp_active;

  // State and burst counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Next-state logic. HALT overrides every state, including a pending press.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    if (mode_i == MODE_HALT) begin
      state_d     = S_IDLE;
      burst_cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (mode_i == MODE_RUN) begin
            state_d = S_RUN;
          end else if (press && (mode_i == MODE_STEP)) begin
            state_d = S_STEP;
          end else if (press && (mode_i == MODE_BURST)) begin
            state_d     = S_BURST;
            burst_cnt_d = (burst_len_i == '0) ? BURST_W'(1) : burst_len_i;
          end
        end
        S_STEP: begin
          state_d = S_IDLE;
        end
        S_BURST: begin
          // Presses and mode changes are ignored until the burst completes.
          if (bp_active) begin
            state_d     = S_BP_HALT;
            burst_cnt_d = '0;
          end else begin
            burst_cnt_d = burst_cnt_q - 1'b1;
            if (burst_cnt_q <= BURST_W'(1)) begin
              state_d     = S_IDLE;
              burst_cnt_d = '0;
            end
          end
        end
        S_RUN: begin
          if (bp_active) begin
            state_d = S_BP_HALT;
          end else if (mode_i != MODE_RUN) begin
            state_d = S_IDLE;
          end
        end
        S_BP_HALT: begin
          // Step once without checking breakpoints, then IDLE re-enters RUN.
          if (press) begin
            state_d = S_STEP;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Count enabled core cycles. The counter wraps naturally at 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt_o <= '0;
    end else if (cpu_en) begin
      cycle_cnt_o <= cycle_cnt_o + 32'd1;
    end
  end

  assign cpu_en_o    = cpu_en;
  assign dbg_state_o = state_q;

endmodule

// File: doc/debug_clk_ctrl.md
# debug_clk_ctrl

Debug clock-enable controller that replaces the raw manual/free-running clock mux in the board top level. The processor core runs on the single board clock and advances only when `cpu_en_o` is high. The controller supports halt, single-step, N-cycle burst and free-run modes from a debounced pushbutton. It also supports optional address breakpoints that stop the core before the matching fetch. It sits between the board switches/keys and the core's clock-enable and PC outputs.

## Interface
Parameters:
- `ADDR_W`, 32, width of the core fetch address
- `NUM_BP`, 2, number of breakpoint comparators
- `BURST_W`, 8, width of the burst length
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles to accept a key level (10 ms at 50 MHz)

Ports:
- `clk`  in  1  board clock
- `reset`  in  1  asynchronous, active-low reset
- `mode_i`  in  2  00 HALT, 01 STEP, 10 BURST, 11 RUN (quasi-static switches)
- `step_key_i`  in  1  raw pushbutton, active-low, asynchronous
- `burst_len_i`  in  BURST_W  cycles per burst; 0 is treated as 1
- `pc_i`  in  ADDR_W  current fetch address from the core
- `bp_addr_i`  in  NUM_BP*ADDR_W  breakpoint addresses, entry i at [i*ADDR_W +: ADDR_W]
- `bp_valid_i`  in  NUM_BP  per-entry enable
- `cpu_en_o`  out  1  core clock enable
- `halted_o`  out  1  high while stopped on a breakpoint
- `bp_hit_o`  out  NUM_BP  sticky per-entry hit flags
- `cycle_cnt_o`  out  32  count of enabled core cycles

## Operation
- Key path:
  - 2-FF synchroniser on `step_key_i`.
  - Debounced level updates only after the synchronised level has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - `press` is a 1-cycle pulse on a debounced 1→0 transition.
- FSM states: IDLE, STEP, BURST, RUN, BP_HALT. `mode_i`=HALT forces IDLE at the next edge from any state, with highest priority after reset.
- IDLE:
  - mode RUN → RUN.
  - `press` with mode STEP → STEP.
  - `press` with mode BURST → BURST; load the counter with `burst_len_i`, or 1 if it is 0.
- STEP: enable for exactly one cycle, then → IDLE.
- BURST:
  - Enable each cycle and decrement the counter; → IDLE after the cycle in which the counter reaches 0.
  - A `press` during a burst is ignored.
  - A mode change to STEP or RUN mid-burst lets the burst finish.
- RUN: enable every cycle; mode ≠ RUN → IDLE.
- Breakpoint match:
  - `match[i]` = `bp_valid_i[i]` && (`pc_i` == entry i).
  - Evaluated in RUN and BURST only.
- `cpu_en_o` = (state ∈ {STEP, BURST, RUN}) && !(state ∈ {RUN, BURST} && |match). The core never executes a cycle at a breakpoint address in RUN/BURST.
- Any match in RUN/BURST → BP_HALT; the matching `bp_hit_o[i]` bits set; a burst is abandoned.
- BP_HALT:
  - `halted_o`=1.
  - `press` → STEP (breakpoints not checked in STEP), clearing `bp_hit_o`. Afterwards IDLE re-enters RUN if the mode is still RUN, so the core steps over the breakpoint.
- `cycle_cnt_o` increments on every cycle with `cpu_en_o`=1 and wraps from 2^32−1 to 0.

## Timing
- Reset values:
  - State IDLE.
  - `cpu_en_o`=0, `halted_o`=0, `bp_hit_o`=0, `cycle_cnt_o`=0.
  - Debounced level 1; synchroniser flops 1; burst counter 0.
- `press` asserts 2+`DEBOUNCE_CYCLES` cycles after the key low is first sampled. `cpu_en_o` rises the cycle after `press`.
- `mode_i` changes take effect one cycle after sampling, because state is registered.
- Breakpoint response is combinational on `pc_i`: `cpu_en_o` drops in the same cycle the match appears. `halted_o`/`bp_hit_o` assert the next cycle.
- Reset mid-burst or mid-debounce aborts immediately and asynchronously. Outputs return to reset values, with no partial step.
- Simultaneous `press` and mode HALT: HALT wins; no step is issued.

## Configuration
- `DBG_BREAKPOINT_EN` defined:
  - Comparators, BP_HALT state and `bp_hit_o` are implemented as described.
- Not defined:
  - `bp_addr_i`, `bp_valid_i` and `pc_i` are ignored, and no comparators are synthesised.
  - `bp_hit_o`=0 and `halted_o`=0 constantly; BP_HALT is unreachable.
  - `cpu_en_o` = (state ∈ {STEP, BURST, RUN}).

## Test plan
- With `DEBOUNCE_CYCLES`=4, mode STEP, key held low for 10 cycles → exactly one `cpu_en_o` pulse, 7 cycles after the first low sample; `cycle_cnt_o`=1.
- Key glitches low for 3 cycles → no `press`, `cpu_en_o` stays 0.
- Mode BURST, `burst_len_i`=5, one press → `cpu_en_o` high for exactly 5 consecutive cycles; `cycle_cnt_o`=5. Repeat with `burst_len_i`=0 → 1 cycle.
- Macro defined, mode RUN, bp0 valid at 0x40, `pc_i` counts 0x30..0x40 → `cpu_en_o` low in the 0x40 cycle. Next cycle `halted_o`=1 and `bp_hit_o`=2'b01. A press gives one enabled cycle, then RUN resumes and `bp_hit_o` clears.
- Mode RUN, then `mode_i` set to HALT → `cpu_en_o` low from the cycle after the change. Reset asserted mid-burst → all outputs at reset values at once.
- Macro undefined, same stimulus as the breakpoint scenario → `cpu_en_o` never drops; `halted_o` and `bp_hit_o` stay 0.
